// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port
// and holds the IF/ID register that feeds DECODE.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemAck,
  output logic [31:0] instrDECO,
  output logic [31:0] pcPlus4DECO,
  output logic        validDECO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BUF   = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  logic        advance;
  logic        avail;
  logic [31:0] avail_instr;
  logic [31:0] avail_pc;

  always_comb begin
    advance     = !stop && !stall;
    avail       = ((state_q == FETCH) && imemAck) || (state_q == BUF);
    avail_instr = (state_q == BUF) ? buf_instr_q : imemRdata;
    avail_pc    = (state_q == BUF) ? buf_pc_q : pc_q;

    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;

    if (advance) begin
      if (flush) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (avail) begin
        instr_d    = avail_instr;
        pc_plus4_d = avail_pc + 32'd4;
        valid_d    = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end

      if (redirect) begin
        pc_d = redirectPC;
      end else if (avail) begin
        pc_d = pc_q + 32'd4;
      end

      // An unanswered request cannot be withdrawn, so it is drained in DROP.
      if ((state_q == FETCH) && !imemAck) begin
        state_d = redirect ? DROP : FETCH;
      end else if ((state_q == DROP) && !imemAck) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: state_d = stop ? IDLE : FETCH;
        FETCH: begin
          if (imemAck) begin
            buf_instr_d = imemRdata;
            buf_pc_d    = pc_q;
            state_d     = BUF;
          end
        end
        DROP: begin
          if (imemAck) begin
            state_d = stop ? IDLE : FETCH;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // A new request always targets the PC as it will be after this edge.
    addr_d = (state_d == FETCH) ? pc_d : addr_q;
    req_d  = (state_d == FETCH) || (state_d == DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // Skid-buffer payload is only meaningful in BUF, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign imemReq     = req_q;
  assign imemAddr    = addr_q;
  assign instrDECO   = instr_q;
  assign pcPlus4DECO = pc_plus4_q;
  assign validDECO   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returns mem[a] = a|1 after a
// programmable number of wait states.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, stop, redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemAck;
  logic [31:0] instrDECO;
  logic [31:0] pcPlus4DECO;
  logic        validDECO;

  int n_chk  = 0;
  int n_pass = 0;
  int waits  = 0;
  int wcnt   = 0;
  logic saw_old_path = 1'b0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .stop       (stop),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .imemAck    (imemAck),
    .instrDECO  (instrDECO),
    .pcPlus4DECO(pcPlus4DECO),
    .validDECO  (validDECO)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge so the ack is seen at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n || !imemReq) begin
      imemAck   = 1'b0;
      imemRdata = 32'hDEAD_BEEF;
      wcnt      = 0;
    end else if (wcnt >= waits) begin
      imemAck   = 1'b1;
      imemRdata = imemAddr | 32'd1;
      wcnt      = 0;
    end else begin
      imemAck   = 1'b0;
      imemRdata = 32'hDEAD_BEEF;
      wcnt      = wcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && validDECO && (instrDECO == 32'h0000_0011)) saw_old_path = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; stop = 1'b0;
    redirect = 1'b0; redirectPC = 32'd0;
    imemAck = 1'b0; imemRdata = 32'hDEAD_BEEF;
    waits = 0;
    tick(2);
    check("rst_req",   {31'd0, imemReq}, 32'd0);
    check("rst_addr",  imemAddr, 32'h0);
    check("rst_valid", {31'd0, validDECO}, 32'd0);
    check("rst_instr", instrDECO, 32'h0);
    check("rst_pc4",   pcPlus4DECO, 32'h0);
    rst_n = 1'b1;

    // Zero-wait streaming
    tick(1);
    check("s1_req0",  {31'd0, imemReq}, 32'd1);
    check("s1_addr0", imemAddr, 32'h0);
    check("s1_val0",  {31'd0, validDECO}, 32'd0);
    tick(1);
    check("s1_addr4", imemAddr, 32'h4);
    check("s1_ins1",  instrDECO, 32'h1);
    check("s1_val1",  {31'd0, validDECO}, 32'd1);
    check("s1_pc4a",  pcPlus4DECO, 32'h4);
    tick(1);
    check("s1_addr8", imemAddr, 32'h8);
    check("s1_ins5",  instrDECO, 32'h5);

    // Stall while the ack for address 8 arrives: skid into BUF
    stall = 1'b1;
    tick(1);
    check("s2_req_off", {31'd0, imemReq}, 32'd0);
    check("s2_hold",    instrDECO, 32'h5);
    tick(2);
    check("s2_req_off2", {31'd0, imemReq}, 32'd0);
    check("s2_hold2",    instrDECO, 32'h5);
    check("s2_pc4hold",  pcPlus4DECO, 32'h8);
    stall = 1'b0;
    tick(1);
    check("s2_ins9",  instrDECO, 32'h9);
    check("s2_pc4c",  pcPlus4DECO, 32'hC);
    check("s2_addrc", imemAddr, 32'hC);
    check("s2_req",   {31'd0, imemReq}, 32'd1);
    tick(1);
    check("s2_insd",  instrDECO, 32'hD);
    check("s2_addr10", imemAddr, 32'h10);

    // Redirect + flush while the ack for 0x10 arrives
    redirect = 1'b1; flush = 1'b1; redirectPC = 32'h40;
    tick(1);
    check("s3_val0",   {31'd0, validDECO}, 32'd0);
    check("s3_nop",    instrDECO, 32'h0);
    check("s3_pc4keep", pcPlus4DECO, 32'h10);
    check("s3_addr40", imemAddr, 32'h40);
    redirect = 1'b0; flush = 1'b0;
    tick(1);
    check("s3_ins41", instrDECO, 32'h41);
    check("s3_val1",  {31'd0, validDECO}, 32'd1);
    check("s3_pc444", pcPlus4DECO, 32'h44);

    // Redirect to 0x10, then 3-wait memory and redirect to 0x80 mid-request
    redirect = 1'b1; redirectPC = 32'h10;
    tick(1);
    check("s4_ins45",  instrDECO, 32'h45);
    check("s4_addr10", imemAddr, 32'h10);
    redirect = 1'b0; waits = 3;
    tick(1);
    check("s4_bubble", {31'd0, validDECO}, 32'd0);
    redirect = 1'b1; redirectPC = 32'h80;
    tick(1);
    check("s4_drop_req",  {31'd0, imemReq}, 32'd1);
    check("s4_drop_addr", imemAddr, 32'h10);
    redirect = 1'b0;
    tick(1);
    check("s4_drop_addr2", imemAddr, 32'h10);
    tick(1);
    check("s4_addr80", imemAddr, 32'h80);
    check("s4_val0",   {31'd0, validDECO}, 32'd0);
    tick(3);
    check("s4_wait_val", {31'd0, validDECO}, 32'd0);
    tick(1);
    check("s4_ins81",  instrDECO, 32'h81);
    check("s4_pc484",  pcPlus4DECO, 32'h84);
    check("s4_addr84", imemAddr, 32'h84);
    check("s4_no_old", {31'd0, saw_old_path}, 32'd0);

    // Stop during an outstanding request to 0x20
    waits = 0; redirect = 1'b1; redirectPC = 32'h20;
    tick(1);
    check("s5_ins85",  instrDECO, 32'h85);
    check("s5_addr20", imemAddr, 32'h20);
    redirect = 1'b0; waits = 3; stop = 1'b1;
    tick(1);
    check("s5_req_pend", {31'd0, imemReq}, 32'd1);
    check("s5_hold",     instrDECO, 32'h85);
    tick(3);
    check("s5_req_off", {31'd0, imemReq}, 32'd0);
    check("s5_hold2",   instrDECO, 32'h85);
    tick(1);
    check("s5_req_off2", {31'd0, imemReq}, 32'd0);
    stop = 1'b0;
    tick(1);
    check("s5_ins21", instrDECO, 32'h21);
    check("s5_pc424", pcPlus4DECO, 32'h24);
    check("s5_addr24", imemAddr, 32'h24);
    check("s5_req_on", {31'd0, imemReq}, 32'd1);

    // Reset in the middle of a wait
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_req",   {31'd0, imemReq}, 32'd0);
    check("s6_addr",  imemAddr, 32'h0);
    check("s6_valid", {31'd0, validDECO}, 32'd0);
    check("s6_instr", instrDECO, 32'h0);
    check("s6_pc4",   pcPlus4DECO, 32'h0);
    tick(2);
    rst_n = 1'b1; waits = 0;
    tick(1);
    check("s6_addr_first", imemAddr, 32'h0);
    check("s6_req_first",  {31'd0, imemReq}, 32'd1);
    tick(1);
    check("s6_ins1", instrDECO, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
